// File: rtl/window_pkg.sv
// window_pkg: shared types, coordinate width and round-robin pick for the window scheduler
package window_pkg;
  localparam int COORD_WIDTH = 16;
  typedef enum logic {IDLE, STREAM} sched_state_e;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] prio);
    rr_pick_t   r;
    logic [2:0] k;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      k = prio + 3'(i);
      if (!r.found && req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/src_tag_fifo.sv
// src_tag_fifo: depth-2 source-id fifo with simultaneous push/pop
module src_tag_fifo #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_q, rd_q, wr, rd;
  logic [1:0]            cnt_q;
  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign head_o  = mem_q[rd_q];
  assign rd      = pop_i && !empty_o;
  assign wr      = push_i && (!full_o || rd);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (wr) mem_q[wr_q] <= data_i;
      wr_q  <= wr_q ^ wr;
      rd_q  <= rd_q ^ rd;
      cnt_q <= cnt_q + 2'(wr) - 2'(rd);
    end
  end
endmodule

// File: rtl/window_frame_scheduler.sv
// window_frame_scheduler: round-robin frame arbiter and coordinate sequencer in front of window_fetcher
module window_frame_scheduler
  import window_pkg::*;
#(
  parameter  int DATA_WIDTH   = 16,
  parameter  int IMAGE_WIDTH  = 64,
  parameter  int IMAGE_HEIGHT = 48,
  parameter  int NUM_SOURCES  = 2,
  localparam int SRC_ID_WIDTH = $clog2(NUM_SOURCES)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SOURCES-1:0]                src_valid_i,
  output logic [NUM_SOURCES-1:0]                src_ready_o,
  output logic [DATA_WIDTH-1:0]                 data_o,
  output logic [COORD_WIDTH-1:0]                col_o,
  output logic [COORD_WIDTH-1:0]                row_o,
  output logic                                  valid_o,
  input  logic                                  win_valid_i,
  input  logic [COORD_WIDTH-1:0]                win_col_i,
  input  logic [COORD_WIDTH-1:0]                win_row_i,
  output logic [SRC_ID_WIDTH-1:0]               win_src_o,
  output logic                                  win_tag_valid_o,
  output logic                                  frame_done_o,
  output logic                                  busy_o,
  output logic                                  err_o
);
  localparam logic [COORD_WIDTH-1:0] COL_LAST = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] ROW_LAST = COORD_WIDTH'(IMAGE_HEIGHT - 1);
  sched_state_e             state_q;
  logic [SRC_ID_WIDTH-1:0]  grant_q, prio_q;
  logic [COORD_WIDTH-1:0]   col_q, row_q;
  logic                     lw_q, fifo_full, fifo_empty, push, pop, hs, col_end, last_px;
  rr_pick_t                 pick;
  assign pick            = rr_pick(8'(src_valid_i), 3'(prio_q));
  assign hs              = state_q == STREAM && src_valid_i[grant_q] && src_ready_o[grant_q];
  assign col_end         = col_q == COL_LAST;
  assign last_px         = hs && col_end && row_q == ROW_LAST;
  assign pop             = lw_q && !fifo_empty;
  assign push            = state_q == IDLE && pick.found && (!fifo_full || pop);
  assign frame_done_o    = pop;
  assign busy_o          = state_q == STREAM;
  assign win_tag_valid_o = !fifo_empty;
  src_tag_fifo #(.WIDTH(SRC_ID_WIDTH)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (SRC_ID_WIDTH'(pick.idx)),
    .head_o  (win_src_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      prio_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      src_ready_o <= '0;
      data_o      <= '0;
      col_o       <= '0;
      row_o       <= '0;
      valid_o     <= 1'b0;
      lw_q        <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      valid_o <= hs;
      lw_q    <= win_valid_i && win_col_i == COL_LAST && win_row_i == ROW_LAST;
      err_o   <= err_o | (lw_q && fifo_empty);
      if (hs) begin
        data_o <= src_data_i[grant_q];
        col_o  <= col_q;
        row_o  <= row_q;
        col_q  <= col_end ? '0 : col_q + 1'b1;
        row_q  <= col_end ? row_q + 1'b1 : row_q;
      end
      if (push) begin
        state_q     <= STREAM;
        grant_q     <= SRC_ID_WIDTH'(pick.idx);
        src_ready_o <= NUM_SOURCES'(1) << pick.idx;
        col_q       <= '0;
        row_q       <= '0;
      end
      if (last_px) begin
        state_q     <= IDLE;
        src_ready_o <= '0;
        prio_q      <= grant_q == SRC_ID_WIDTH'(NUM_SOURCES - 1) ? '0 : grant_q + 1'b1;
        col_q       <= '0;
        row_q       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_window_frame_scheduler.sv
// tb_window_frame_scheduler: scoreboard bench for window_frame_scheduler with a looped-back fetcher model
module tb_window_frame_scheduler;
  localparam int W = 4;
  localparam int H = 3;
  typedef struct {
    logic [15:0] d;
    logic [15:0] c;
    logic [15:0] r;
  } exp_t;
  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0][15:0] src_data_i;
  logic [1:0]       src_valid_i;
  logic [1:0]       src_ready_o;
  logic [15:0]      data_o, col_o, row_o;
  logic             valid_o;
  logic             win_valid_i;
  logic [15:0]      win_col_i, win_row_i;
  logic             win_src_o;
  logic             win_tag_valid_o, frame_done_o, busy_o, err_o;
  int               n_chk = 0;
  int               n_err = 0;
  int               done_cnt = 0;
  int               pix_idx = 0;
  int               cyc = 0;
  int               last_end = -1;
  logic             loop_en = 1'b0;
  logic             gap_en = 1'b0;
  logic             pv[2];
  logic [15:0]      pc[2], pr[2];
  exp_t             exp_q[$];
  int               tag_q[$];
  int               gq[$];
  logic [1:0]       prev_rdy = '0;
  window_frame_scheduler #(
    .DATA_WIDTH(16), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_SOURCES(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .src_data_i(src_data_i), .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o), .data_o(data_o), .col_o(col_o), .row_o(row_o), .valid_o(valid_o),
    .win_valid_i(win_valid_i), .win_col_i(win_col_i), .win_row_i(win_row_i), .win_src_o(win_src_o),
    .win_tag_valid_o(win_tag_valid_o), .frame_done_o(frame_done_o), .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int s = 0; s < 2; s++) src_data_i[s] = 16'($urandom);
    if (!rst_ni) begin
      pv[0] = 1'b0; pv[1] = 1'b0;
      pc[0] = '0; pc[1] = '0; pr[0] = '0; pr[1] = '0;
    end
    if (loop_en) begin
      win_valid_i = pv[1]; win_col_i = pc[1]; win_row_i = pr[1];
      pv[1] = pv[0]; pc[1] = pc[0]; pr[1] = pr[0];
      pv[0] = valid_o; pc[0] = col_o; pr[0] = row_o;
    end
  endtask
  task automatic apply_reset();
    rst_ni = 1'b0; src_valid_i = '0; loop_en = 1'b0; gap_en = 1'b0;
    win_valid_i = 1'b0; win_col_i = '0; win_row_i = '0;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_ready"}, src_ready_o, 0);
    chk({p, "_valid"}, valid_o, 0);
    chk({p, "_data"}, data_o, 0);
    chk({p, "_col"}, col_o, 0);
    chk({p, "_row"}, row_o, 0);
    chk({p, "_done"}, frame_done_o, 0);
    chk({p, "_busy"}, busy_o, 0);
    chk({p, "_err"}, err_o, 0);
    chk({p, "_tagv"}, win_tag_valid_o, 0);
    chk({p, "_src"}, win_src_o, 0);
  endtask
  task automatic wait_done(input int k, input int budget, input string tag);
    int start = done_cnt;
    int n = 0;
    while (done_cnt < start + k && n < budget) begin
      tick();
      n++;
    end
    chk(tag, done_cnt >= start + k, 1);
  endtask
  always @(negedge clk_i) begin : mon
    exp_t e;
    cyc++;
    if (!rst_ni) begin
      exp_q.delete(); tag_q.delete(); gq.delete();
      pix_idx = 0; last_end = -1; prev_rdy = '0;
    end else begin
      if (valid_o) begin
        chk("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", data_o, e.d);
          chk("col", col_o, e.c);
          chk("row", row_o, e.r);
        end
      end
      if (frame_done_o) begin
        done_cnt++;
        chk("tag_q_nonempty", tag_q.size() != 0, 1);
        if (tag_q.size() != 0) chk("win_src", win_src_o, tag_q.pop_front());
      end
      chk("ready_onehot0", $onehot0(src_ready_o), 1);
      if (src_ready_o != 0 && prev_rdy == 0) begin
        for (int s = 0; s < 2; s++) if (src_ready_o[s]) begin
          tag_q.push_back(s);
          gq.push_back(s);
        end
        if (gap_en && last_end >= 0) chk("bubble", cyc - last_end, 2);
      end
      for (int s = 0; s < 2; s++) if (src_valid_i[s] && src_ready_o[s]) begin
        e.d = src_data_i[s];
        e.c = 16'(pix_idx % W);
        e.r = 16'(pix_idx / W);
        exp_q.push_back(e);
        if (pix_idx == W * H - 1) begin
          pix_idx = 0;
          last_end = cyc;
        end else pix_idx++;
      end
      prev_rdy = src_ready_o;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    rst_ni = 1'b0; src_valid_i = '0; src_data_i = '0;
    win_valid_i = 1'b0; win_col_i = '0; win_row_i = '0;
    pv[0] = 1'b0; pv[1] = 1'b0; pc[0] = '0; pc[1] = '0; pr[0] = '0; pr[1] = '0;
    repeat (3) tick();
    chk_reset("rst");
    rst_ni = 1'b1;
    loop_en = 1'b1; gap_en = 1'b1; src_valid_i = 2'b01;
    wait_done(2, 200, "single_src_done");
    apply_reset();
    loop_en = 1'b1; gap_en = 1'b1; src_valid_i = 2'b11;
    wait_done(4, 300, "alt_done");
    chk("alt_ngrant", gq.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("alt_grant", i < gq.size() ? gq[i] : 99, i % 2);
    apply_reset();
    loop_en = 1'b1; src_valid_i = 2'b10;
    n = 0;
    while (pix_idx != 2 && n < 100) begin
      tick();
      n++;
    end
    chk("stall_reach", pix_idx, 2);
    src_valid_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid_low", valid_o, 0);
    end
    src_valid_i = 2'b10;
    tick();
    chk("resume_valid", valid_o, 1);
    chk("resume_col", col_o, 2);
    chk("resume_row", row_o, 0);
    wait_done(1, 100, "stall_done");
    apply_reset();
    src_valid_i = 2'b11;
    repeat (40) tick();
    chk("full_busy", busy_o, 0);
    chk("full_ready", src_ready_o, 0);
    chk("full_tagv", win_tag_valid_o, 1);
    chk("full_head", win_src_o, 0);
    win_valid_i = 1'b1; win_col_i = 16'(W - 1); win_row_i = 16'(H - 1);
    tick();
    win_valid_i = 1'b0;
    chk("full_pop_done", frame_done_o, 1);
    tick();
    chk("third_grant_ready", src_ready_o, 2'b01);
    chk("third_grant_busy", busy_o, 1);
    apply_reset();
    win_valid_i = 1'b1; win_col_i = 16'(W - 1); win_row_i = 16'(H - 1);
    tick();
    win_valid_i = 1'b0;
    chk("err_no_done", frame_done_o, 0);
    tick();
    chk("err_set", err_o, 1);
    repeat (3) tick();
    chk("err_sticky", err_o, 1);
    chk("err_tagv", win_tag_valid_o, 0);
    apply_reset();
    chk("err_cleared", err_o, 0);
    loop_en = 1'b1; src_valid_i = 2'b01;
    n = 0;
    while (pix_idx < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_reach", pix_idx, 5);
    rst_ni = 1'b0; src_valid_i = 2'b00;
    tick();
    chk_reset("mid_rst");
    rst_ni = 1'b1; src_valid_i = 2'b11;
    n = 0;
    while (!valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("restart_valid", valid_o, 1);
    chk("restart_col", col_o, 0);
    chk("restart_row", row_o, 0);
    chk("restart_src", gq.size() > 0 ? gq[0] : 99, 0);
    src_valid_i = 2'b00;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
